// File: rtl/wf_neopixel_frame_buf_if.sv
// Pixel write handshake between a frame writer and the neopixel frame buffer.
interface wf_neopixel_frame_buf_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/wf_neopixel_frame_buf.sv
// Double-buffered 5/5/5 pixel store; swaps front/back only at frame_sync,
// and expands front-buffer pixels to dimmed 24-bit neopixel words.
module wf_neopixel_frame_buf #(
    parameter int NUM_OF_PIXELS = 8,
    parameter int DIM_SHIFT     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    wf_neopixel_frame_buf_if.slave  wr,
    output logic                    wr_err_o,
    input  logic                    clear_i,
    input  logic                    commit_i,
    output logic                    commit_pending_o,
    input  logic                    frame_sync_i,
    input  logic [7:0]              ram_rd_addr_i,
    output logic [23:0]             ram_rd_data_o,
    output logic [7:0]              swap_count_o
);

    localparam int AW = $clog2(2 * NUM_OF_PIXELS);
    localparam logic [7:0] NPIX      = 8'(NUM_OF_PIXELS);
    localparam logic [7:0] INIT_LAST = 8'(2 * NUM_OF_PIXELS - 1);
    localparam logic [7:0] CLR_LAST  = 8'(NUM_OF_PIXELS - 1);
    localparam logic [AW-1:0] BUF1   = AW'(NUM_OF_PIXELS);

    typedef enum logic [1:0] {
        S_INIT,
        S_CLEAR,
        S_IDLE,
        S_PEND
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        front_sel_q;
    logic        commit_pending_q;
    logic        wr_ready_q;
    logic        wr_err_q;
    logic [7:0]  swap_count_q;
    logic [23:0] rd_data_q;
    logic [23:0] rd_data_d;

    logic [14:0] mem_q [2 * NUM_OF_PIXELS];

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [14:0]   mem_wdata;
    logic [AW-1:0] back_base;
    logic [AW-1:0] front_base;
    logic [AW-1:0] rd_idx;
    logic          wr_accept;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          unused_wr_msb;

    function automatic logic [7:0] expand(input logic [4:0] c);
        logic [7:0] e;
        e = {c, c[4:2]};
        return e >> DIM_SHIFT;
    endfunction

    assign unused_wr_msb = wr.wr_data[15];
    assign wr_accept     = wr.wr_valid && wr_ready_q;
    assign wr_in_range   = wr.wr_addr < NPIX;
    assign rd_in_range   = ram_rd_addr_i < NPIX;
    // {sel, addr} layout generalised to non power-of-two frame sizes
    assign back_base     = front_sel_q ? '0 : BUF1;
    assign front_base    = front_sel_q ? BUF1 : '0;
    assign rd_idx        = front_base + AW'(ram_rd_addr_i);

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_INIT: begin
                mem_we   = !reset;
                mem_widx = AW'(cnt_q);
            end
            S_CLEAR: begin
                mem_we   = !reset;
                mem_widx = back_base + AW'(cnt_q);
            end
            S_IDLE: begin
                mem_we    = !reset && wr_accept && wr_in_range;
                mem_widx  = back_base + AW'(wr.wr_addr);
                mem_wdata = wr.wr_data[14:0];
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            rd_data_d = {expand(mem_q[rd_idx][14:10]),
                         expand(mem_q[rd_idx][9:5]),
                         expand(mem_q[rd_idx][4:0])};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_INIT;
            cnt_q            <= '0;
            front_sel_q      <= 1'b0;
            commit_pending_q <= 1'b0;
            wr_ready_q       <= 1'b0;
            wr_err_q         <= 1'b0;
            swap_count_q     <= '0;
            rd_data_q        <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            wr_err_q  <= wr_accept && !wr_in_range;
            unique case (state_q)
                S_INIT, S_CLEAR: begin
                    if (commit_i) begin
                        commit_pending_q <= 1'b1;
                    end
                    if (cnt_q == ((state_q == S_INIT) ? INIT_LAST : CLR_LAST)) begin
                        cnt_q <= '0;
                        if (commit_pending_q || commit_i) begin
                            state_q <= S_PEND;
                        end else begin
                            state_q    <= S_IDLE;
                            wr_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_IDLE: begin
                    if (clear_i) begin
                        state_q    <= S_CLEAR;
                        cnt_q      <= '0;
                        wr_ready_q <= 1'b0;
                        if (commit_i) begin
                            commit_pending_q <= 1'b1;
                        end
                    end else if (commit_i) begin
                        state_q          <= S_PEND;
                        commit_pending_q <= 1'b1;
                        wr_ready_q       <= 1'b0;
                    end
                end
                S_PEND: begin
                    if (frame_sync_i) begin
                        front_sel_q      <= !front_sel_q;
                        swap_count_q     <= swap_count_q + 8'd1;
                        commit_pending_q <= 1'b0;
                        wr_ready_q       <= 1'b1;
                        state_q          <= S_IDLE;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign wr.wr_ready      = wr_ready_q;
    assign wr_err_o         = wr_err_q;
    assign commit_pending_o = commit_pending_q;
    assign ram_rd_data_o    = rd_data_q;
    assign swap_count_o     = swap_count_q;

endmodule

// File: tb/tb_wf_neopixel_frame_buf.sv
// Scoreboard bench for wf_neopixel_frame_buf: directed writes, commits,
// clears and resets, with read results and write errors checked by monitors.
module tb_wf_neopixel_frame_buf;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        commit = 1'b0;
    logic        frame_sync = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        wr_err;
    logic        pend;
    logic [23:0] rd_data;
    logic [7:0]  swap_cnt;

    wf_neopixel_frame_buf_if wr_if();

    wf_neopixel_frame_buf #(
        .NUM_OF_PIXELS(N),
        .DIM_SHIFT(1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr               (wr_if),
        .wr_err_o         (wr_err),
        .clear_i          (clear),
        .commit_i         (commit),
        .commit_pending_o (pend),
        .frame_sync_i     (frame_sync),
        .ram_rd_addr_i    (rd_addr),
        .ram_rd_data_o    (rd_data),
        .swap_count_o     (swap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] err_q[$];
    int         total = 0;
    int         bad = 0;
    logic       rd_issue = 1'b0;
    logic       rd_issue_d = 1'b0;
    logic [7:0] acc_addr_d = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // read monitor: data is valid one clock after the address was issued
    always @(posedge clk) begin
        rd_issue_d <= rd_issue;
        if (wr_if.wr_valid && wr_if.wr_ready) acc_addr_d <= wr_if.wr_addr;
    end

    always @(negedge clk) begin
        if (rd_issue_d) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk(e.name, {8'h0, rd_data}, {8'h0, e.exp});
            end
        end
        if (wr_err) begin
            if (err_q.size() == 0) begin
                chk("wr_err_unexpected", 1, 0);
            end else begin
                logic [7:0] a;
                a = err_q.pop_front();
                chk("wr_err_addr", {24'h0, acc_addr_d}, {24'h0, a});
            end
        end
    end

    task automatic wait_ready(input int maxc, output int n);
        n = 0;
        while (!wr_if.wr_ready && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!wr_if.wr_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        int n;
        wait_ready(40, n);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        if (a >= N) err_q.push_back(a);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [7:0] a,
                           input logic [23:0] exp);
        rd_exp_t e;
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
        rd_addr  = a;
        rd_issue = 1'b1;
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic pulse(input logic c, input logic cl, input logic fs);
        commit     = c;
        clear      = cl;
        frame_sync = fs;
        @(negedge clk);
        commit     = 1'b0;
        clear      = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (!wr_if.wr_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, 2 * N);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = '0;
        wr_if.wr_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", wr_if.wr_ready, 0);
        chk("rst_swap", swap_cnt, 0);
        chk("rst_pend", pend, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_err", wr_err, 0);
        reset = 1'b0;
        count_init("init_clks");
        for (int i = 0; i < N; i++) do_read("init_zero", 8'(i), 24'h0);
        chk("t1_swap", swap_cnt, 0);

        do_write(8'd3, 16'h7FFF);
        pulse(1'b1, 1'b0, 1'b0);
        chk("t2_pend_set", pend, 1);
        chk("t2_ready_low", wr_if.wr_ready, 0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t2_pend_drop", pend, 0);
        chk("t2_swap", swap_cnt, 1);
        chk("t2_ready_back", wr_if.wr_ready, 1);
        do_read("t2_addr3", 8'd3, 24'h7F7F7F);
        do_read("t2_addr2", 8'd2, 24'h0);

        do_write(8'd9, 16'h1234);
        do_write(8'd8, 16'h7FFF);
        do_write(8'd7, 16'h7C00);
        do_write(8'd0, 16'h001F);
        do_read("t3_addr9", 8'd9, 24'h0);
        do_read("t3_addr8", 8'd8, 24'h0);
        do_read("t3_front3", 8'd3, 24'h7F7F7F);

        pulse(1'b1, 1'b0, 1'b0);
        chk("t4_ready_low", wr_if.wr_ready, 0);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 8'd5;
        wr_if.wr_data  = 16'h03E0;
        repeat (3) @(negedge clk);
        wr_if.wr_valid = 1'b0;
        chk("t4_still_pend", pend, 1);
        do_read("t4_front_kept", 8'd3, 24'h7F7F7F);
        do_read("t4_front7", 8'd7, 24'h0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t4_swap1", swap_cnt, 2);
        chk("t4_pend_drop", pend, 0);
        repeat (2) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t4_no_2nd_swap", swap_cnt, 2);
        do_read("t4_addr0", 8'd0, 24'h00007F);
        do_read("t4_addr7", 8'd7, 24'h7F0000);
        do_read("t4_addr5", 8'd5, 24'h0);
        do_read("t4_addr3", 8'd3, 24'h0);

        begin
            int n;
            wait_ready(40, n);
        end
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 8'd2;
        wr_if.wr_data  = 16'h5294;
        commit         = 1'b1;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        commit         = 1'b0;
        chk("t4b_pend", pend, 1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t4b_swap", swap_cnt, 3);
        do_read("t4b_addr2", 8'd2, 24'h525252);
        do_read("t4b_prev3", 8'd3, 24'h7F7F7F);

        pulse(1'b1, 1'b1, 1'b0);
        chk("t5_ready_low", wr_if.wr_ready, 0);
        chk("t5_pend", pend, 1);
        @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t5_fs_in_clear", swap_cnt, 3);
        repeat (10) @(negedge clk);
        chk("t5_ready_pend", wr_if.wr_ready, 0);
        chk("t5_still_pend", pend, 1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t5_swap", swap_cnt, 4);
        do_read("t5_addr0", 8'd0, 24'h0);
        do_read("t5_addr7", 8'd7, 24'h0);

        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_ready_low", wr_if.wr_ready, 0);
        count_init("t6_init_clks");
        chk("t6_swap_rst", swap_cnt, 0);
        chk("t6_pend_rst", pend, 0);
        do_read("t6_addr2", 8'd2, 24'h0);
        do_read("t6_addr3", 8'd3, 24'h0);
        do_write(8'd1, 16'h0421);
        do_write(8'd4, 16'h8000);
        do_write(8'd6, 16'h03E0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t6_swap", swap_cnt, 1);
        do_read("t6_addr1", 8'd1, 24'h040404);
        do_read("t6_addr4", 8'd4, 24'h0);
        do_read("t6_addr6", 8'd6, 24'h007F00);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        chk("t7_pend_init", pend, 1);
        repeat (20) @(negedge clk);
        chk("t7_ready_low", wr_if.wr_ready, 0);
        chk("t7_pend_kept", pend, 1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t7_swap", swap_cnt, 1);
        chk("t7_ready", wr_if.wr_ready, 1);

        repeat (3) @(negedge clk);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
